// File: rtl/cpu_parameters.sv
// Shared CPU-wide parameters and the register-file write-port payload.
// Contents: XLEN, register count/index width, default producer-tag width,
// and rf_port_t (valid, adr, data, tag) for carrying one write-back port.
package cpu_parameters;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned NREGS        = 32;
  localparam int unsigned REG_ADRW     = 5;
  localparam int unsigned TAGW_DEFAULT = 4;

  // One register-file write-back port.
  typedef struct packed {
    logic                    valid;
    logic [REG_ADRW-1:0]     adr;
    logic [XLEN-1:0]         data;
    logic [TAGW_DEFAULT-1:0] tag;
  } rf_port_t;

endpackage

// File: rtl/intirvx_scoreboard_entry.sv
// Scoreboard state for a single architectural register: busy bit and owner tag.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   flush         clear busy; an alloc in the same cycle is discarded
//   alloc         claim this register; alloc_tag becomes the owner
//   wr_valid      a write-back (highest-priority port) targets this register
//   wr_tag        producer tag of that write-back
//   busy          registered pending flag
//   wr_match_c    combinational: write tag matches the current owner while busy
module intirvx_scoreboard_entry #(
  parameter int unsigned TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            alloc,
  input  logic [TAGW-1:0] alloc_tag,
  input  logic            wr_valid,
  input  logic [TAGW-1:0] wr_tag,
  output logic            busy,
  output logic            wr_match_c
);

  logic [TAGW-1:0] owner;

  // A stale producer (tag != owner) must not release the register.
  assign wr_match_c = wr_valid && busy && (wr_tag == owner);

  // Priority: flush, then alloc (beats a same-cycle release), then release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      owner <= '0;
    end else if (flush) begin
      busy  <= 1'b0;
    end else if (alloc) begin
      busy  <= 1'b1;
      owner <= alloc_tag;
    end else if (wr_match_c) begin
      busy  <= 1'b0;
    end
  end

endmodule

// File: rtl/intirvx_scoreboard_regfile.sv
// Integer register file with a per-register scoreboard (busy + owner tag).
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   wr_valid/wr_adr/wr_data/wr_tag   NWR write-back ports (higher index wins)
//   rd_en/rd_adr -> rd_data/rd_ready NRD combinational read ports
//   alloc_valid/alloc_adr/alloc_tag  destination claim from issue
//   flush                            drop all pending claims
//   busy_any                         any register currently pending
module intirvx_scoreboard_regfile
  import cpu_parameters::*;
#(
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 1,
  parameter int unsigned TAGW   = TAGW_DEFAULT,
  parameter int unsigned BYPASS = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NWR-1:0]                wr_valid,
  input  logic [NWR-1:0][REG_ADRW-1:0]  wr_adr,
  input  logic [NWR-1:0][XLEN-1:0]      wr_data,
  input  logic [NWR-1:0][TAGW-1:0]      wr_tag,
  input  logic [NRD-1:0]                rd_en,
  input  logic [NRD-1:0][REG_ADRW-1:0]  rd_adr,
  output logic [NRD-1:0][XLEN-1:0]      rd_data,
  output logic [NRD-1:0]                rd_ready,
  input  logic                          alloc_valid,
  input  logic [REG_ADRW-1:0]           alloc_adr,
  input  logic [TAGW-1:0]               alloc_tag,
  input  logic                          flush,
  output logic                          busy_any
);

  logic [XLEN-1:0]  mem      [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] wr_match;
  logic [NREGS-1:0] sel_valid;
  logic [TAGW-1:0]  sel_tag  [NREGS];
  logic [XLEN-1:0]  sel_data [NREGS];

  // Per register, the winning write-back port; ascending scan lets the
  // highest port index override. Index 0 never selects a write.
  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      sel_valid[r] = 1'b0;
      sel_tag[r]   = '0;
      sel_data[r]  = '0;
      for (int unsigned p = 0; p < NWR; p++) begin
        if (wr_valid[p] && (wr_adr[p] == REG_ADRW'(r)) && (r != 0)) begin
          sel_valid[r] = 1'b1;
          sel_tag[r]   = wr_tag[p];
          sel_data[r]  = wr_data[p];
        end
      end
    end
  end

  // Scoreboard entries; entry 0 never sees an alloc or write so stays idle.
  for (genvar r = 0; r < NREGS; r++) begin : g_entry
    intirvx_scoreboard_entry #(
      .TAGW (TAGW)
    ) u_entry (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .alloc      (alloc_valid && (alloc_adr == REG_ADRW'(r)) && (r != 0)),
      .alloc_tag  (alloc_tag),
      .wr_valid   (sel_valid[r]),
      .wr_tag     (sel_tag[r]),
      .busy       (busy[r]),
      .wr_match_c (wr_match[r])
    );
  end

  // Data array: written regardless of tag; flush does not block data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        mem[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        if (sel_valid[r]) begin
          mem[r] <= sel_data[r];
        end
      end
    end
  end

  // Combinational read with optional forwarding of a matching-tag write.
  always_comb begin
    rd_data  = '0;
    rd_ready = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      if (rd_en[i]) begin
        if (rd_adr[i] == '0) begin
          rd_ready[i] = 1'b1;
        end else if ((BYPASS != 0) && wr_match[rd_adr[i]]) begin
          rd_data[i]  = sel_data[rd_adr[i]];
          rd_ready[i] = 1'b1;
        end else begin
          rd_data[i]  = mem[rd_adr[i]];
          rd_ready[i] = !busy[rd_adr[i]];
        end
      end
    end
  end

  assign busy_any = |busy;

endmodule

// File: tb/tb_intirvx_scoreboard_regfile.sv
// Self-checking bench: a driver issues one stimulus per cycle and queues the
// reference model's expected read response; a monitor pops and compares.
module tb_intirvx_scoreboard_regfile;
  import cpu_parameters::*;

  localparam int unsigned NRD = 2;
  localparam int unsigned NWR = 2;
  localparam int unsigned TW  = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NWR-1:0]        wr_valid = '0;
  logic [NWR-1:0][4:0]   wr_adr   = '0;
  logic [NWR-1:0][31:0]  wr_data  = '0;
  logic [NWR-1:0][TW-1:0] wr_tag  = '0;
  logic [NRD-1:0]        rd_en    = '0;
  logic [NRD-1:0][4:0]   rd_adr   = '0;
  logic [NRD-1:0][31:0]  rd_data;
  logic [NRD-1:0]        rd_ready;
  logic                  alloc_valid = 1'b0;
  logic [4:0]            alloc_adr   = '0;
  logic [TW-1:0]         alloc_tag   = '0;
  logic                  flush       = 1'b0;
  logic                  busy_any;

  intirvx_scoreboard_regfile #(
    .NRD(NRD), .NWR(NWR), .TAGW(TW), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_adr(wr_adr), .wr_data(wr_data), .wr_tag(wr_tag),
    .rd_en(rd_en), .rd_adr(rd_adr), .rd_data(rd_data), .rd_ready(rd_ready),
    .alloc_valid(alloc_valid), .alloc_adr(alloc_adr), .alloc_tag(alloc_tag),
    .flush(flush), .busy_any(busy_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d [NRD];
    logic        r [NRD];
    logic        b;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference state
  logic [31:0]   mdata [32];
  logic [31:0]   mbusy;
  logic [TW-1:0] mown  [32];

  // Stimulus staged for the next cycle
  logic [NWR-1:0]         s_wv;
  logic [NWR-1:0][4:0]    s_wa;
  logic [NWR-1:0][31:0]   s_wd;
  logic [NWR-1:0][TW-1:0] s_wt;
  logic [NRD-1:0]         s_re;
  logic [NRD-1:0][4:0]    s_ra;
  logic                   s_av;
  logic [4:0]             s_aa;
  logic [TW-1:0]          s_at;
  logic                   s_fl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 32; a++) begin
      mdata[a] = '0;
      mown[a]  = '0;
    end
    mbusy = '0;
  endtask

  // Highest-index write port targeting register a this cycle, or -1.
  function automatic int last_writer(input logic [4:0] a);
    int w = -1;
    for (int p = 0; p < int'(NWR); p++)
      if (s_wv[p] && s_wa[p] == a && a != 0) w = p;
    return w;
  endfunction

  function automatic exp_t model_read();
    exp_t e;
    for (int i = 0; i < int'(NRD); i++) begin
      logic [4:0] a = s_ra[i];
      int w = last_writer(a);
      e.d[i] = '0;
      e.r[i] = 1'b0;
      if (s_re[i]) begin
        if (a == 0) e.r[i] = 1'b1;
        else if (w >= 0 && mbusy[a] && s_wt[w] == mown[a]) begin
          e.d[i] = s_wd[w];
          e.r[i] = 1'b1;
        end else begin
          e.d[i] = mdata[a];
          e.r[i] = !mbusy[a];
        end
      end
    end
    e.b = (mbusy != 0);
    return e;
  endfunction

  task automatic model_step();
    logic [31:0]   nbusy = mbusy;
    logic [TW-1:0] nown [32];
    for (int a = 1; a < 32; a++) begin
      int   w = last_writer(5'(a));
      logic released = 1'b0;
      nown[a] = mown[a];
      if (w >= 0) begin
        mdata[a] = s_wd[w];
        released = mbusy[a] && (s_wt[w] == mown[a]);
      end
      if (s_fl) nbusy[a] = 1'b0;
      else if (s_av && s_aa == 5'(a)) begin
        nbusy[a] = 1'b1;
        nown[a]  = s_at;
      end else if (released) nbusy[a] = 1'b0;
    end
    mbusy = nbusy;
    for (int a = 1; a < 32; a++) mown[a] = nown[a];
  endtask

  task automatic clear_stim();
    s_wv = '0; s_wa = '0; s_wd = '0; s_wt = '0;
    s_re = '0; s_ra = '0;
    s_av = 1'b0; s_aa = '0; s_at = '0; s_fl = 1'b0;
  endtask

  task automatic rand_stim();
    s_wv = NWR'($urandom_range(0, 3));
    for (int p = 0; p < int'(NWR); p++) begin
      s_wa[p] = 5'($urandom_range(0, 7));
      s_wd[p] = $urandom;
      s_wt[p] = ($urandom_range(0, 1) == 1) ? mown[s_wa[p]] : TW'($urandom_range(0, 3));
    end
    s_re = NRD'($urandom_range(0, 3));
    for (int i = 0; i < int'(NRD); i++) s_ra[i] = 5'($urandom_range(0, 7));
    s_av = 1'($urandom_range(0, 1));
    s_aa = 5'($urandom_range(0, 7));
    s_at = TW'($urandom_range(0, 3));
    s_fl = ($urandom_range(0, 15) == 0);
  endtask

  // Drive staged stimulus on the falling edge and queue the expected response.
  task automatic do_cycle();
    @(negedge clk);
    wr_valid = s_wv; wr_adr = s_wa; wr_data = s_wd; wr_tag = s_wt;
    rd_en = s_re; rd_adr = s_ra;
    alloc_valid = s_av; alloc_adr = s_aa; alloc_tag = s_at; flush = s_fl;
    q.push_back(model_read());
    model_step();
  endtask

  // Monitor: compare after combinational settling, mid low phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int i = 0; i < int'(NRD); i++) begin
          chk($sformatf("sb_rd_data%0d", i), rd_data[i], e.d[i]);
          chk($sformatf("sb_rd_ready%0d", i), 32'(rd_ready[i]), 32'(e.r[i]));
        end
        chk("sb_busy_any", 32'(busy_any), 32'(e.b));
      end
    end
  end

  initial begin
    model_reset();
    clear_stim();

    // Read during reset
    #2;
    rd_en = 2'b01; rd_adr[0] = 5'd5;
    #1;
    chk("rst_rd_data", rd_data[0], 32'h0);
    chk("rst_rd_ready", 32'(rd_ready[0]), 32'h1);
    chk("rst_busy_any", 32'(busy_any), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Alloc x5 tag 3, pending read, bypassed matching write, then idle
    clear_stim(); s_av = 1; s_aa = 5; s_at = 3; do_cycle();
    clear_stim(); s_re = 2'b01; s_ra[0] = 5; do_cycle(); #2;
    chk("x5_pending_ready", 32'(rd_ready[0]), 32'h0);
    chk("x5_pending_busy_any", 32'(busy_any), 32'h1);
    clear_stim(); s_re = 2'b01; s_ra[0] = 5;
    s_wv = 2'b01; s_wa[0] = 5; s_wd[0] = 32'hA5; s_wt[0] = 3; do_cycle(); #2;
    chk("x5_bypass_data", rd_data[0], 32'hA5);
    chk("x5_bypass_ready", 32'(rd_ready[0]), 32'h1);
    clear_stim(); do_cycle(); #2;
    chk("x5_released_busy_any", 32'(busy_any), 32'h0);

    // Stale tag on x7
    clear_stim(); s_av = 1; s_aa = 7; s_at = 2; do_cycle();
    clear_stim(); s_av = 1; s_aa = 7; s_at = 4; do_cycle();
    clear_stim(); s_re = 2'b01; s_ra[0] = 7;
    s_wv = 2'b01; s_wa[0] = 7; s_wd[0] = 32'h11; s_wt[0] = 2; do_cycle(); #2;
    chk("x7_stale_no_bypass", 32'(rd_ready[0]), 32'h0);
    clear_stim(); s_re = 2'b01; s_ra[0] = 7; do_cycle(); #2;
    chk("x7_stale_data", rd_data[0], 32'h11);
    chk("x7_stale_ready", 32'(rd_ready[0]), 32'h0);
    clear_stim(); s_re = 2'b10; s_ra[1] = 7;
    s_wv = 2'b10; s_wa[1] = 7; s_wd[1] = 32'h22; s_wt[1] = 4; do_cycle(); #2;
    chk("x7_owner_bypass", rd_data[1], 32'h22);
    clear_stim(); s_re = 2'b10; s_ra[1] = 7; do_cycle(); #2;
    chk("x7_owner_ready", 32'(rd_ready[1]), 32'h1);

    // Flush interactions on x9 / x10
    clear_stim(); s_av = 1; s_aa = 9; s_at = 1; s_fl = 1; do_cycle();
    clear_stim(); s_re = 2'b01; s_ra[0] = 9; do_cycle(); #2;
    chk("x9_flush_alloc_ready", 32'(rd_ready[0]), 32'h1);
    clear_stim(); s_av = 1; s_aa = 10; s_at = 1; do_cycle();
    clear_stim(); s_fl = 1; s_re = 2'b10; s_ra[1] = 10; do_cycle(); #2;
    chk("x10_before_flush_ready", 32'(rd_ready[1]), 32'h0);
    clear_stim(); s_re = 2'b10; s_ra[1] = 10; do_cycle(); #2;
    chk("x10_after_flush_ready", 32'(rd_ready[1]), 32'h1);
    chk("x10_after_flush_busy_any", 32'(busy_any), 32'h0);

    // Two ports writing x4 in one cycle
    clear_stim(); s_av = 1; s_aa = 4; s_at = 5; do_cycle();
    clear_stim(); s_wv = 2'b11; s_wa[0] = 4; s_wa[1] = 4;
    s_wd[0] = 32'h1; s_wd[1] = 32'h2; s_wt[0] = 5; s_wt[1] = 5;
    s_re = 2'b01; s_ra[0] = 4; do_cycle(); #2;
    chk("x4_dual_bypass", rd_data[0], 32'h2);
    clear_stim(); s_re = 2'b01; s_ra[0] = 4; do_cycle(); #2;
    chk("x4_dual_data", rd_data[0], 32'h2);
    chk("x4_dual_ready", 32'(rd_ready[0]), 32'h1);

    // Alloc beats a same-cycle matching write on x6
    clear_stim(); s_av = 1; s_aa = 6; s_at = 1; do_cycle();
    clear_stim(); s_av = 1; s_aa = 6; s_at = 2;
    s_wv = 2'b01; s_wa[0] = 6; s_wd[0] = 32'h33; s_wt[0] = 1; do_cycle();
    clear_stim(); s_re = 2'b01; s_ra[0] = 6; do_cycle(); #2;
    chk("x6_alloc_wins_data", rd_data[0], 32'h33);
    chk("x6_alloc_wins_ready", 32'(rd_ready[0]), 32'h0);

    // Write and alloc to x0 are ignored
    clear_stim(); s_av = 1; s_aa = 0; s_at = 3;
    s_wv = 2'b01; s_wa[0] = 0; s_wd[0] = 32'hDEAD; do_cycle();
    clear_stim(); s_re = 2'b11; s_ra[0] = 0; s_ra[1] = 0; do_cycle(); #2;
    chk("x0_data", rd_data[0], 32'h0);
    chk("x0_ready", 32'(rd_ready[1]), 32'h1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rand_stim();
      do_cycle();
    end

    // Asynchronous reset mid-cycle with x3 pending
    clear_stim(); s_av = 1; s_aa = 3; s_at = 7; do_cycle();
    clear_stim(); s_re = 2'b01; s_ra[0] = 3; do_cycle(); #2;
    chk("x3_pending_ready", 32'(rd_ready[0]), 32'h0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("x3_async_rst_ready", 32'(rd_ready[0]), 32'h1);
    chk("x3_async_rst_data", rd_data[0], 32'h0);
    chk("x3_async_rst_busy_any", 32'(busy_any), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wr_valid = '0; alloc_valid = 1'b0; flush = 1'b0;
    clear_stim(); s_re = 2'b01; s_ra[0] = 5; do_cycle(); #2;
    chk("x5_data_after_rst", rd_data[0], 32'h0);

    for (int n = 0; n < 100; n++) begin
      rand_stim();
      do_cycle();
    end

    clear_stim();
    do_cycle();
    repeat (4) @(negedge clk);
    #3;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d entries left expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
